// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings for transmitter and receiver,
// line-level frame constants and a counter-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_CLEANUP = 3'd4
    } rx_state_t;

    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: 8N1-style frames (start, DATA_LEN bits LSB first, stop)
// with a one-entry holding register so consecutive frames run without gaps.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_LEN     = 8,
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_start,
    input  logic [DATA_LEN-1:0] tx_data,
    output logic                tx_ready,
    output logic                tx_active,
    output logic                tx_serial,
    output logic                tx_done
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int BW = cnt_width(DATA_LEN);

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_DONE = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_LEN - 1);

    tx_state_t           state;
    logic [CW-1:0]       clk_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [DATA_LEN-1:0] shifter;
    logic [DATA_LEN-1:0] hold;
    logic                hold_full;

    logic accept;
    logic bit_end;
    logic queue_req;

    assign accept  = tx_start && tx_ready;
    assign bit_end = (clk_cnt == CLK_LAST);

    // Requests arriving mid-frame go to the holding register, except on the
    // stop-bit boundary where an empty holding register lets the new byte
    // start directly.
    always_comb begin
        queue_req = 1'b0;
        if (accept) begin
            case (state)
                START_BIT, DATA_BITS: queue_req = 1'b1;
                STOP_BIT:             queue_req = !bit_end;
                default:              queue_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx_serial <= FRAME_STOP;
            tx_done   <= 1'b0;
            tx_ready  <= 1'b1;
            tx_active <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (queue_req) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
                tx_ready  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    clk_cnt   <= '0;
                    bit_cnt   <= '0;
                    tx_serial <= FRAME_STOP;
                    tx_active <= 1'b0;
                    tx_ready  <= 1'b1;
                    if (accept) begin
                        shifter   <= tx_data;
                        state     <= START_BIT;
                        tx_serial <= FRAME_START;
                        tx_active <= 1'b1;
                    end
                end

                START_BIT: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        bit_cnt   <= '0;
                        tx_serial <= shifter[0];
                        shifter   <= shifter >> 1;
                        state     <= DATA_BITS;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA_BITS: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            tx_serial <= FRAME_STOP;
                            state     <= STOP_BIT;
                        end else begin
                            tx_serial <= shifter[0];
                            shifter   <= shifter >> 1;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP_BIT: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        if (hold_full) begin
                            shifter   <= hold;
                            hold_full <= 1'b0;
                            tx_ready  <= 1'b1;
                            state     <= START_BIT;
                            tx_serial <= FRAME_START;
                        end else if (accept) begin
                            shifter   <= tx_data;
                            state     <= START_BIT;
                            tx_serial <= FRAME_START;
                        end else begin
                            state     <= IDLE;
                            tx_serial <= FRAME_STOP;
                            tx_active <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                        // tx_done is registered, so raise it one edge early.
                        if (clk_cnt == CLK_DONE)
                            tx_done <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    clk_cnt   <= '0;
                    bit_cnt   <= '0;
                    hold_full <= 1'b0;
                    tx_serial <= FRAME_STOP;
                    tx_active <= 1'b0;
                    tx_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
